fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_SIZE, default 11, SHALL set the program-counter and memory-address width in bits.
REQ-002 Parameter INSTR_SIZE, default 16, SHALL set the instruction word width in bits.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port pc, input, ADDR_SIZE bits, SHALL carry the current program counter from the PC register.
REQ-006 Port pc_load, output, 1 bit, SHALL be the PC register load strobe.
REQ-007 Port pc_inc, output, 1 bit, SHALL be the PC register increment strobe.
REQ-008 Port pc_next, output, ADDR_SIZE bits, SHALL be the PC register load value.
REQ-009 Port mem_req, output, 1 bit, SHALL be the instruction-memory read request.
REQ-010 Port mem_addr, output, ADDR_SIZE bits, SHALL be the read address.
REQ-011 Port mem_ack, input, 1 bit, SHALL mark mem_rdata as valid.
REQ-012 Port mem_rdata, input, INSTR_SIZE bits, SHALL be the read data.
REQ-013 Port br_valid, input, 1 bit, SHALL request a redirect to br_target (ADDR_SIZE bits, input).
REQ-014 Port instr, output, INSTR_SIZE bits, SHALL carry the fetched instruction to decode.
REQ-015 Port instr_valid, output, 1 bit, and port instr_ready, input, 1 bit, SHALL form the decode handshake.

Function
REQ-016 The FSM SHALL have the states REQ, WAIT, HOLD, DISCARD and HALT.
REQ-017 REQ: mem_req=1 and mem_addr=pc for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-018 WAIT: mem_req=0; on mem_ack the block SHALL capture mem_rdata into instr, pulse pc_inc for one cycle and go to HOLD; with no mem_ack it SHALL remain in WAIT indefinitely.
REQ-019 HOLD: instr_valid=1 and instr SHALL be stable; when instr_ready=1 the transfer completes and the FSM SHALL go to REQ on the next cycle.
REQ-020 The minimum fetch-to-fetch period SHALL be 3 cycles (REQ, WAIT with same-cycle ack, HOLD with instr_ready=1).
REQ-021 br_valid=1 in any state other than HALT SHALL drive pc_load=1 and pc_next=br_target in that cycle; pc_inc SHALL be 0 in that cycle; instr_valid SHALL be forced to 0 in that cycle.
REQ-022 On branch: from REQ the FSM SHALL go to DISCARD (the issued request is outstanding); from WAIT without mem_ack it SHALL go to DISCARD; from WAIT with mem_ack, HOLD or DISCARD-with-ack it SHALL go to REQ; from DISCARD without ack it SHALL remain in DISCARD.
REQ-023 DISCARD: the block SHALL drop mem_rdata on mem_ack without pulsing pc_inc, then go to REQ.
REQ-024 pc_load and pc_inc SHALL never be asserted in the same cycle; pc_next SHALL equal br_target whenever pc_load=1 and 0 otherwise.
REQ-025 PC wrap-around (all ones to 0) SHALL be left to the PC register; the block SHALL apply no special handling.
REQ-026 A branch in a HOLD cycle with instr_ready=1 SHALL cancel the transfer; decode SHALL treat instr_valid as 0.

Reset
REQ-027 While rst=1, the block SHALL drive state=REQ, instr=0, instr_valid=0, mem_req=0, pc_load=0, pc_inc=0 and pc_next=0; rst SHALL override br_valid and mem_ack.
REQ-028 The first mem_req SHALL occur in the first cycle after rst is released.
REQ-029 Reset asserted during WAIT SHALL discard the outstanding response; a mem_ack arriving in REQ SHALL be ignored.

Configuration
REQ-030 With macro FETCH_HALT_EN defined, capturing an instruction of all ones SHALL present it in HOLD and, after the handshake, SHALL move the FSM to HALT with pc_inc suppressed for that instruction.
REQ-031 In HALT, mem_req, pc_inc and pc_load SHALL be 0 and br_valid SHALL be ignored until rst.
REQ-032 Without FETCH_HALT_EN, HALT SHALL be unreachable and all-ones SHALL be fetched like any other word.

Verification
REQ-033 Reset release with pc=0, mem_ack one cycle after the request, rdata=16'h1234, instr_ready=1 -> mem_addr=0, instr=16'h1234 with instr_valid for 1 cycle, one pc_inc pulse, next request 3 cycles after the first.
REQ-034 instr_ready held at 0 for 5 cycles in HOLD -> instr held stable, no new mem_req, pc_inc pulsed once only.
REQ-035 br_valid with br_target=11'h2A0 in WAIT, ack 2 cycles later -> pc_load=1 with pc_next=11'h2A0 for 1 cycle, response dropped, no pc_inc, next mem_addr=11'h2A0.
REQ-036 rst asserted in WAIT, then mem_ack during reset -> all outputs 0, no instr_valid, clean fetch after release.
REQ-037 FETCH_HALT_EN defined, rdata=16'hFFFF -> presented once, then no mem_req for 20 cycles despite br_valid; without the macro the fetch continues normally.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: PC-register, instruction-memory, branch and decode signals of the fetch unit.
// master = fetch_unit side, slave = PC register / memory / decode side.
interface fetch_if #(
  parameter int ADDR_SIZE  = 11,
  parameter int INSTR_SIZE = 16
) ();
  logic [ADDR_SIZE-1:0]  pc;
  logic                  pc_load;
  logic                  pc_inc;
  logic [ADDR_SIZE-1:0]  pc_next;
  logic                  mem_req;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic                  mem_ack;
  logic [INSTR_SIZE-1:0] mem_rdata;
  logic                  br_valid;
  logic [ADDR_SIZE-1:0]  br_target;
  logic [INSTR_SIZE-1:0] instr;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    input  pc,
    output pc_load,
    output pc_inc,
    output pc_next,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  br_valid,
    input  br_target,
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    output pc,
    input  pc_load,
    input  pc_inc,
    input  pc_next,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output br_valid,
    output br_target,
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: REQ/WAIT/HOLD/DISCARD/HALT fetch FSM; ports clk, rst (sync, high), bus (fetch_if.master).
// FETCH_HALT_EN: an all-ones instruction halts fetch after its handshake.
module fetch_unit #(
  parameter int ADDR_SIZE  = 11,
  parameter int INSTR_SIZE = 16
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [INSTR_SIZE-1:0] instr_q;
  logic                  halt_q;
  logic                  is_ones;
  logic                  br;
  logic                  take;

`ifdef FETCH_HALT_EN
  assign is_ones = &bus.mem_rdata;
`else
  assign is_ones = 1'b0;
`endif

  // HALT is deaf to branches
  assign br   = bus.br_valid && (state != S_HALT);
  assign take = (state == S_WAIT) && bus.mem_ack
             && !bus.br_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      halt_q  <= 1'b0;
    end else if (take) begin
      instr_q <= bus.mem_rdata;
      halt_q  <= is_ones;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        // request already issued: a branch must
        // still swallow its response
        state_nxt = br ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (br) begin
          state_nxt = bus.mem_ack ? S_REQ
                                  : S_DISCARD;
        end else if (bus.mem_ack) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (br) begin
          state_nxt = S_REQ;
        end else if (bus.instr_ready) begin
          state_nxt = halt_q ? S_HALT : S_REQ;
        end
      end
      S_DISCARD: begin
        if (bus.mem_ack) begin
          state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.pc_load     = 1'b0;
    bus.pc_next     = '0;
    bus.pc_inc      = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    if (!rst) begin
      bus.instr   = instr_q;
      bus.pc_load = br;
      bus.pc_next = br ? bus.br_target : '0;
      unique case (state)
        S_REQ: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = bus.pc;
        end
        S_WAIT: begin
          // a halting word leaves the PC on itself
          bus.pc_inc = take && !is_ones;
        end
        S_HOLD: begin
          bus.instr_valid = !bus.br_valid;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a PC register and a
// latency-programmable memory responder.
module tb_fetch_unit;

  localparam int AW = 11;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_SIZE(AW), .INSTR_SIZE(IW)) bus ();

  fetch_unit #(
    .ADDR_SIZE (AW),
    .INSTR_SIZE(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // program counter register
  always @(posedge clk) begin
    if (rst) bus.pc <= '0;
    else if (bus.pc_load) bus.pc <= bus.pc_next;
    else if (bus.pc_inc) bus.pc <= bus.pc + 1'b1;
  end

  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic [IW-1:0] exp_q[$];
  int            req_cyc[$];

  int total = 0;
  int bad   = 0;
  int n_req = 0;
  int n_inc = 0;
  int n_load = 0;
  int n_xfer = 0;
  int cyc_no = 0;
  int ack_cnt = 0;
  int lat = 1;
  int base_inc;
  int base_req;
  int base_load;
  logic [AW-1:0] ack_addr;
  logic [IW-1:0] hold_v;

  logic          s_req, s_inc, s_load, s_valid;
  logic [AW-1:0] s_addr, s_next;
  logic [IW-1:0] s_instr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock: drive responder at posedge+1, sample at negedge
  task automatic cyc();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[ack_addr];
      end
    end
    @(negedge clk);
    s_req   = bus.mem_req;
    s_inc   = bus.pc_inc;
    s_load  = bus.pc_load;
    s_valid = bus.instr_valid;
    s_addr  = bus.mem_addr;
    s_next  = bus.pc_next;
    s_instr = bus.instr;
    if (s_req) n_req++;
    if (s_inc) n_inc++;
    if (s_load) n_load++;
    chk("ld_and_inc", 32'(s_load && s_inc), 0);
    if (!s_load) chk("next_zero", 32'(s_next), 0);
    if (rst) begin
      chk("rst_strobes",
          32'({s_req, s_inc, s_load, s_valid}), 0);
      chk("rst_instr", 32'(s_instr), 0);
    end
    if (s_valid && bus.instr_ready) begin
      n_xfer++;
      if (exp_q.size() == 0)
        chk("sb_extra", 32'(exp_q.size()), 1);
      else
        chk("sb_instr", 32'(s_instr),
            32'(exp_q.pop_front()));
    end
    if (s_req) begin
      ack_cnt  = lat;
      ack_addr = s_addr;
      req_cyc.push_back(cyc_no);
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = IW'(16'h5000 + i);
    mem[0]      = 16'h1234;
    mem[11'h100] = 16'hFFFF;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.instr_ready = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    @(posedge clk);
    #1;

    // reset state
    repeat (3) cyc();

    // basic fetch, 3-cycle period
    exp_q.push_back(16'h1234);
    rst = 1'b0;
    cyc();
    chk("first_req", 32'(s_req), 1);
    chk("first_addr", 32'(s_addr), 0);
    cyc();
    chk("wait_noreq", 32'(s_req), 0);
    chk("first_inc", 32'(s_inc), 1);
    cyc();
    chk("hold_valid", 32'(s_valid), 1);
    chk("hold_instr", 32'(s_instr), 32'h1234);
    cyc();
    chk("refetch", 32'(s_req), 1);
    chk("gap", 32'(req_cyc[1] - req_cyc[0]), 3);
    chk("inc_once", 32'(n_inc), 1);
    chk("addr1", 32'(s_addr), 1);

    // decode stall in HOLD
    bus.instr_ready = 1'b0;
    exp_q.push_back(mem[1]);
    cyc();
    cyc();
    chk("stall_valid0", 32'(s_valid), 1);
    hold_v   = s_instr;
    base_req = n_req;
    repeat (4) begin
      cyc();
      chk("stall_instr", 32'(s_instr), 32'(hold_v));
      chk("stall_valid", 32'(s_valid), 1);
    end
    chk("stall_noreq", 32'(n_req - base_req), 0);
    chk("stall_inc", 32'(n_inc), 2);
    bus.instr_ready = 1'b1;
    cyc();
    chk("stall_xfer", 32'(n_xfer), 2);

    // branch during WAIT, late response dropped
    lat = 3;
    cyc();
    chk("s3_req", 32'(s_req), 1);
    chk("s3_addr", 32'(s_addr), 2);
    base_inc      = n_inc;
    bus.br_valid  = 1'b1;
    bus.br_target = 11'h2A0;
    cyc();
    chk("br_load", 32'(s_load), 1);
    chk("br_next", 32'(s_next), 32'h2A0);
    chk("br_inc", 32'(s_inc), 0);
    chk("br_valid0", 32'(s_valid), 0);
    bus.br_valid = 1'b0;
    lat = 1;
    cyc();
    cyc();
    chk("drop_inc", 32'(n_inc - base_inc), 0);
    chk("drop_load", 32'(n_load), 1);
    exp_q.push_back(mem[11'h2A0]);
    cyc();
    chk("br_refetch", 32'(s_req), 1);
    chk("br_addr", 32'(s_addr), 32'h2A0);
    cyc();
    cyc();
    chk("br_drain", 32'(exp_q.size()), 0);

    // reset in WAIT, ack under reset
    lat = 3;
    cyc();
    chk("s4_req", 32'(s_req), 1);
    chk("s4_addr", 32'(s_addr), 32'h2A1);
    base_inc = n_inc;
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_noinc", 32'(n_inc - base_inc), 0);
    // stray ack lands in the first REQ cycle
    lat      = 1;
    ack_cnt  = 1;
    ack_addr = 11'h5;
    exp_q.push_back(16'h1234);
    rst = 1'b0;
    cyc();
    chk("rel_req", 32'(s_req), 1);
    chk("rel_addr", 32'(s_addr), 0);
    cyc();
    cyc();
    chk("rel_drain", 32'(exp_q.size()), 0);
    chk("rel_instr", 32'(s_instr), 32'h1234);

    // branch in REQ to an all-ones word
    bus.br_valid  = 1'b1;
    bus.br_target = 11'h100;
    cyc();
    chk("s5_req", 32'(s_req), 1);
    chk("s5_load", 32'(s_load), 1);
    bus.br_valid = 1'b0;
    cyc();
    chk("s5_discard", 32'(s_valid), 0);
    base_inc = n_inc;
    exp_q.push_back(16'hFFFF);
    cyc();
    chk("ff_req", 32'(s_req), 1);
    chk("ff_addr", 32'(s_addr), 32'h100);
    cyc();
    cyc();
    chk("ff_drain", 32'(exp_q.size()), 0);
    chk("ff_instr", 32'(s_instr), 32'hFFFF);
`ifdef FETCH_HALT_EN
    chk("halt_inc", 32'(n_inc - base_inc), 0);
    base_req  = n_req;
    base_load = n_load;
    for (int i = 0; i < 20; i++) begin
      bus.br_valid  = i[0];
      bus.br_target = 11'h010;
      cyc();
    end
    bus.br_valid = 1'b0;
    chk("halt_noreq", 32'(n_req - base_req), 0);
    chk("halt_noload", 32'(n_load - base_load), 0);
    chk("halt_noinc", 32'(n_inc - base_inc), 0);
`else
    chk("ff_inc", 32'(n_inc - base_inc), 1);
    cyc();
    chk("ff_next_req", 32'(s_req), 1);
    chk("ff_next_addr", 32'(s_addr), 32'h101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
